// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-display sequencer: view states,
// ALU probe item count and the fill word shown after the ALU flags.
package dbg_pkg;

  typedef enum logic [2:0] {
    S_INSTR = 3'd0,
    S_REG   = 3'd1,
    S_ALU   = 3'd2,
    S_DMEM  = 3'd3,
    S_LED   = 3'd4
  } dbg_state_e;

  localparam int          ALU_ITEMS = 5;
  localparam logic [31:0] ALU_FILL  = 32'hFFFF_FFFF;

  // Picks the ALU probe word for a given walk position
  function automatic logic [31:0] alu_item(input logic [2:0]  idx,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] c,
                                           input logic        zero);
    logic [31:0] word;
    word = ALU_FILL;
    case (idx)
      3'd0:    word = a;
      3'd1:    word = b;
      3'd2:    word = c;
      3'd3:    word = {31'h0, zero};
      default: word = ALU_FILL;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/dbg_wrap_cnt.sv
// Wrapping scan index: counts 0..N-1 and back to 0, with a synchronous
// clear that takes priority over counting.
module dbg_wrap_cnt #(
  parameter int N     = 5,
  parameter int IDX_W = 6
) (
  input  logic             Clk_CPU,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  // Next index: clear wins, otherwise advance with wrap at N-1
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Index register
  always_ff @(posedge Clk_CPU or negedge rstn) begin
    if (!rstn) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/dbg_disp_scan.sv
// Debug-display sequencer: decodes the requested view from the switches,
// walks the selected debug source and registers the word for seg7x16.
module dbg_disp_scan
  import dbg_pkg::*;
#(
  parameter int RF_NUM  = 32,
  parameter int DM_NUM  = 16,
  parameter int LED_NUM = 48,
  parameter int IDX_W   = 6
) (
  input  logic             Clk_CPU,
  input  logic             rstn,
  input  logic [3:0]       sel_i,
  input  logic             led_i,
  input  logic             hold_i,
  input  logic [31:0]      instr_i,
  output logic [4:0]       rf_addr_o,
  input  logic [31:0]      rf_data_i,
  output logic [IDX_W-1:0] dm_addr_o,
  input  logic [31:0]      dm_data_i,
  input  logic [31:0]      alu_a_i,
  input  logic [31:0]      alu_b_i,
  input  logic [31:0]      alu_c_i,
  input  logic             alu_zero_i,
  output logic [IDX_W-1:0] led_idx_o,
  input  logic [63:0]      led_pat_i,
  output logic [63:0]      display_data_o,
  output logic             disp_mode_o
);

  dbg_state_e       state_q, state_d, target;
  logic [63:0]      disp_q, disp_d;
  logic             mode_q, mode_d;
  logic             change;

  logic [IDX_W-1:0] reg_idx, alu_idx, dm_idx, led_idx;
  logic             reg_clr, alu_clr, dm_clr, led_clr;
  logic             reg_en, alu_en, dm_en, led_en;
  logic             unused_bits;

  // Requested view: LED overrides, then instr > reg > alu > dmem, idle shows instr
  always_comb begin
    target = S_INSTR;
    if (led_i)         target = S_LED;
    else if (sel_i[3]) target = S_INSTR;
    else if (sel_i[2]) target = S_REG;
    else if (sel_i[1]) target = S_ALU;
    else if (sel_i[0]) target = S_DMEM;
  end

  assign change = (target != state_q);

  // Counter controls: the entered view's index restarts, the active view walks
  always_comb begin
    reg_clr = change && (target == S_REG);
    alu_clr = change && (target == S_ALU);
    dm_clr  = change && (target == S_DMEM);
    led_clr = change && (target == S_LED);
    reg_en  = !change && (state_q == S_REG)  && !hold_i;
    alu_en  = !change && (state_q == S_ALU);
    dm_en   = !change && (state_q == S_DMEM) && !hold_i;
    led_en  = !change && (state_q == S_LED);
  end

  dbg_wrap_cnt #(.N(RF_NUM), .IDX_W(IDX_W)) u_reg_cnt (
    .Clk_CPU(Clk_CPU), .rstn(rstn), .clr(reg_clr), .en(reg_en), .idx(reg_idx)
  );

  dbg_wrap_cnt #(.N(ALU_ITEMS), .IDX_W(IDX_W)) u_alu_cnt (
    .Clk_CPU(Clk_CPU), .rstn(rstn), .clr(alu_clr), .en(alu_en), .idx(alu_idx)
  );

  dbg_wrap_cnt #(.N(DM_NUM), .IDX_W(IDX_W)) u_dm_cnt (
    .Clk_CPU(Clk_CPU), .rstn(rstn), .clr(dm_clr), .en(dm_en), .idx(dm_idx)
  );

  dbg_wrap_cnt #(.N(LED_NUM), .IDX_W(IDX_W)) u_led_cnt (
    .Clk_CPU(Clk_CPU), .rstn(rstn), .clr(led_clr), .en(led_en), .idx(led_idx)
  );

  // Next display word: blank on a view change, else the current item of the walk
  always_comb begin
    state_d = target;
    mode_d  = (target == S_LED);
    disp_d  = 64'h0;
    if (!change) begin
      case (state_q)
        S_INSTR: disp_d = {32'h0, instr_i};
        S_REG:   disp_d = {32'h0, reg_idx[3:0], rf_data_i[27:0]};
        S_ALU:   disp_d = {32'h0, alu_item(alu_idx[2:0], alu_a_i, alu_b_i,
                                           alu_c_i, alu_zero_i)};
        S_DMEM:  disp_d = {32'h0, dm_idx[3:0], dm_data_i[27:0]};
        S_LED:   disp_d = led_pat_i;
        default: disp_d = 64'h0;
      endcase
    end
  end

  // View state and registered display outputs
  always_ff @(posedge Clk_CPU or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_INSTR;
      disp_q  <= 64'h0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      mode_q  <= mode_d;
    end
  end

  assign rf_addr_o      = reg_idx[4:0];
  assign dm_addr_o      = dm_idx;
  assign led_idx_o      = led_idx;
  assign display_data_o = disp_q;
  assign disp_mode_o    = mode_q;

  // Bits deliberately not shown on the display or used for addressing
  assign unused_bits = ^{rf_data_i[31:28], dm_data_i[31:28],
                         reg_idx[IDX_W-1:5], alu_idx[IDX_W-1:3]};

endmodule

// File: tb/tb_dbg_disp_scan.sv
// Randomised and directed bench for dbg_disp_scan against a view-level model.
module tb_dbg_disp_scan;

  localparam int IDX_W = 6;

  logic             Clk_CPU = 1'b0;
  logic             rstn;
  logic [3:0]       sel_i;
  logic             led_i;
  logic             hold_i;
  logic [31:0]      instr_i;
  logic [4:0]       rf_addr_o;
  logic [31:0]      rf_data_i;
  logic [IDX_W-1:0] dm_addr_o;
  logic [31:0]      dm_data_i;
  logic [31:0]      alu_a_i, alu_b_i, alu_c_i;
  logic             alu_zero_i;
  logic [IDX_W-1:0] led_idx_o;
  logic [63:0]      led_pat_i;
  logic [63:0]      display_data_o;
  logic             disp_mode_o;

  logic [31:0] rf_mem  [0:31];
  logic [31:0] dm_mem  [0:63];
  logic [63:0] led_rom [0:63];

  int checkCount = 0;
  int errorCount = 0;
  bit randData   = 1'b1;

  // View-level reference: 0 instr, 1 reg, 2 alu, 3 dmem, 4 led
  int          mView;
  int          mIdx [5];
  int          walkLen [5] = '{1, 32, 5, 16, 48};
  logic [63:0] mDisp;
  logic        mMode;

  always #5 Clk_CPU = ~Clk_CPU;

  assign rf_data_i = rf_mem[rf_addr_o];
  assign dm_data_i = dm_mem[dm_addr_o];
  assign led_pat_i = led_rom[led_idx_o];

  dbg_disp_scan dut (
    .Clk_CPU(Clk_CPU), .rstn(rstn), .sel_i(sel_i), .led_i(led_i),
    .hold_i(hold_i), .instr_i(instr_i), .rf_addr_o(rf_addr_o),
    .rf_data_i(rf_data_i), .dm_addr_o(dm_addr_o), .dm_data_i(dm_data_i),
    .alu_a_i(alu_a_i), .alu_b_i(alu_b_i), .alu_c_i(alu_c_i),
    .alu_zero_i(alu_zero_i), .led_idx_o(led_idx_o), .led_pat_i(led_pat_i),
    .display_data_o(display_data_o), .disp_mode_o(disp_mode_o)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mView = 0;
    for (int i = 0; i < 5; i++) mIdx[i] = 0;
    mDisp = 64'h0;
    mMode = 1'b0;
  endtask

  function automatic int requestedView();
    if (led_i)    return 4;
    if (sel_i[3]) return 0;
    if (sel_i[2]) return 1;
    if (sel_i[1]) return 2;
    if (sel_i[0]) return 3;
    return 0;
  endfunction

  function automatic logic [63:0] itemOf(int view, int idx);
    logic [31:0] aluList [5];
    aluList = '{alu_a_i, alu_b_i, alu_c_i, {31'h0, alu_zero_i}, 32'hFFFF_FFFF};
    case (view)
      1:       return 64'((idx % 16) * 32'h1000_0000 + (rf_mem[idx] & 32'h0FFF_FFFF));
      2:       return 64'(aluList[idx]);
      3:       return 64'((idx % 16) * 32'h1000_0000 + (dm_mem[idx] & 32'h0FFF_FFFF));
      4:       return led_rom[idx];
      default: return 64'(instr_i);
    endcase
  endfunction

  task automatic modelStep();
    int tgt;
    tgt = requestedView();
    if (tgt != mView) begin
      mView       = tgt;
      mIdx[tgt]   = 0;
      mDisp       = 64'h0;
    end else begin
      mDisp = itemOf(mView, mIdx[mView]);
      if (!(hold_i && (mView == 1 || mView == 3)))
        mIdx[mView] = (mIdx[mView] + 1) % walkLen[mView];
    end
    mMode = (mView == 4);
  endtask

  task automatic checkAll();
    checkOutput("display", display_data_o, mDisp);
    checkOutput("mode", 64'(disp_mode_o), 64'(mMode));
    checkOutput("rf_addr", 64'(rf_addr_o), 64'(mIdx[1] % 32));
    checkOutput("dm_addr", 64'(dm_addr_o), 64'(mIdx[3]));
    checkOutput("led_idx", 64'(led_idx_o), 64'(mIdx[4]));
  endtask

  // Drives one cycle of inputs (caller sits at a negedge), clocks, then checks
  task automatic applyStimulus(input logic [3:0] sel, input logic led,
                               input logic hold);
    sel_i  = sel;
    led_i  = led;
    hold_i = hold;
    if (randData) begin
      instr_i    = $urandom;
      alu_a_i    = $urandom;
      alu_b_i    = $urandom;
      alu_c_i    = $urandom;
      alu_zero_i = 1'($urandom_range(0, 1));
    end
    @(posedge Clk_CPU);
    modelStep();
    @(negedge Clk_CPU);
    checkAll();
  endtask

  initial begin
    logic [3:0] rs;
    logic       rl;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    for (int i = 0; i < 64; i++) dm_mem[i] = $urandom;
    for (int i = 0; i < 64; i++) led_rom[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) rf_mem[i] = 32'hABCD_1234;
    rstn = 1'b0; sel_i = 4'b0100; led_i = 1'b0; hold_i = 1'b0;
    instr_i = 32'h0; alu_a_i = 32'h0; alu_b_i = 32'h0; alu_c_i = 32'h0;
    alu_zero_i = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_disp", display_data_o, 64'h0);
    checkOutput("reset_mode", 64'(disp_mode_o), 64'h0);
    checkOutput("reset_led_idx", 64'(led_idx_o), 64'h0);
    @(negedge Clk_CPU);
    rstn = 1'b1;

    // Register walk from reset
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("reg_trans_blank", display_data_o, 64'h0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("reg_item0", display_data_o, 64'h0000_0000_0BCD_1234);
    checkOutput("reg_addr1", 64'(rf_addr_o), 64'd1);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("reg_item1", display_data_o, 64'h0000_0000_1BCD_1234);
    checkOutput("reg_addr2", 64'(rf_addr_o), 64'd2);
    for (int i = 0; i < 30; i++) applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("reg_tag_f", 64'(display_data_o[31:28]), 64'hF);
    checkOutput("reg_wrap", 64'(rf_addr_o), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 1'b0, 1'b1);
      checkOutput("reg_hold_addr", 64'(rf_addr_o), 64'd5);
      checkOutput("reg_hold_tag", 64'(display_data_o[31:28]), 64'd5);
    end

    // ALU probe walk with fixed operands
    randData = 1'b0;
    alu_a_i = 32'd1; alu_b_i = 32'd2; alu_c_i = 32'd3; alu_zero_i = 1'b1;
    begin
      logic [31:0] aluExp [7];
      aluExp = '{32'h0, 32'd1, 32'd2, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd1};
      for (int i = 0; i < 7; i++) begin
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("alu_seq", display_data_o, 64'(aluExp[i]));
      end
    end
    randData = 1'b1;

    // Data memory walk interrupted by the ALU view
    for (int i = 0; i < 8; i++) applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("dm_at7", 64'(dm_addr_o), 64'd7);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    checkOutput("dm_to_alu_blank", display_data_o, 64'h0);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("dm_reentry_blank", display_data_o, 64'h0);
    checkOutput("dm_reentry_addr", 64'(dm_addr_o), 64'd0);

    // LED animation full wrap, then drop back to instruction view
    for (int i = 0; i < 49; i++) applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("led_mode", 64'(disp_mode_o), 64'd1);
    checkOutput("led_wrap", 64'(led_idx_o), 64'd0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("led_exit_mode", 64'(disp_mode_o), 64'd0);

    // Asynchronous reset in the middle of an LED walk
    for (int i = 0; i < 21; i++) applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("led_at20", 64'(led_idx_o), 64'd20);
    #2 rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("async_disp", display_data_o, 64'h0);
    checkOutput("async_mode", 64'(disp_mode_o), 64'h0);
    checkOutput("async_led_idx", 64'(led_idx_o), 64'h0);
    @(negedge Clk_CPU);
    rstn = 1'b1;

    // Random view switching, holds and data
    rs = 4'b0100;
    rl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) rl = ~rl;
      applyStimulus(rs, rl, 1'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dbg_disp_scan.md
Name: dbg_disp_scan

Overview:
Debug-display sequencer between the pipelined CPU core and the seg7x16 driver. It replaces the per-mode scan counters in the top level. Switch inputs select what is shown:
- current ID-stage instruction
- register-file walk
- ALU probe walk
- data-memory walk
- 64-bit LED animation
The block drives RF/DM debug read addresses and a registered 64-bit word plus display-mode bit for seg7x16.

Parameters:
RF_NUM, 32, number of RF entries walked (indices 0..RF_NUM-1)
DM_NUM, 16, number of DM words walked (indices 0..DM_NUM-1)
LED_NUM, 48, number of LED animation frames (indices 0..LED_NUM-1)
IDX_W, 6, width of all scan indices; must satisfy 2^IDX_W >= max(RF_NUM, DM_NUM, LED_NUM)

Ports:
Clk_CPU  in  1  CPU clock
rstn  in  1  reset, asynchronous, active-low
sel_i  in  4  one-hot view select: [3] instr, [2] reg, [1] alu, [0] dmem
led_i  in  1  LED animation mode; overrides sel_i
hold_i  in  1  freeze reg/dmem walk indices
instr_i  in  32  ID-stage instruction
rf_addr_o  out  5  RF debug read address (= reg index[4:0])
rf_data_i  in  32  RF debug read data, combinational from rf_addr_o
dm_addr_o  out  IDX_W  DM debug word address (= dmem index)
dm_data_i  in  32  DM debug read data, combinational
alu_a_i, alu_b_i, alu_c_i  in  32 each  ALU operand A, operand B, result
alu_zero_i  in  1  ALU zero flag
led_idx_o  out  IDX_W  LED frame ROM address
led_pat_i  in  64  LED frame data, combinational from led_idx_o
display_data_o  out  64  word to seg7x16
disp_mode_o  out  1  seg7x16 mode: 1 = raw segment pattern, 0 = hex

Behaviour:
Reset (async, rstn low):
- state = S_INSTR
- all indices = 0
- display_data_o = 64'h0
- disp_mode_o = 0
- Mid-walk reset: indices return to 0 immediately; first post-reset edge behaves as in S_INSTR.

States and decode:
- States: S_INSTR, S_REG, S_ALU, S_DMEM, S_LED.
- Target state is decoded each cycle:
  - led_i=1 -> S_LED
  - else priority sel_i[3] > [2] > [1] > [0]
  - sel_i=0 -> S_INSTR
- On any edge where target != current state: state <= target, the target's index <= 0, display_data_o <= 0, no item is shown that cycle. The walk starts on the following edge.
- Index of the state being left is not preserved; re-entry always starts at 0.

Walk rule (per edge, state unchanged):
- display_data_o <= item[idx]
- idx <= (idx == N-1) ? 0 : idx+1
- Latency: item for index k appears at display_data_o on the same edge that advances idx from k to k+1.
- Address outputs are driven combinationally from the index registers.

Per-state items:
- S_INSTR: display = {32'h0, instr_i}, updated every edge. No index.
- S_REG: N = RF_NUM.
  - display = {32'h0, idx[3:0], rf_data_i[27:0]}
  - hold_i=1: idx frozen; display still refreshes from the current idx.
- S_ALU: N = 5; hold_i ignored.
  - idx 0: alu_a_i
  - idx 1: alu_b_i
  - idx 2: alu_c_i
  - idx 3: {31'h0, alu_zero_i}
  - idx 4: 32'hFFFF_FFFF
  - Each item is placed in display[31:0], upper 32 bits = 0.
- S_DMEM: N = DM_NUM; display = {32'h0, idx[3:0], dm_data_i[27:0]}; hold_i behaves as in S_REG.
- S_LED: N = LED_NUM.
  - display = led_pat_i
  - disp_mode_o <= 1 on the transition edge into S_LED; 0 in all other states
  - hold_i ignored

Width rules:
- Index compare uses the full IDX_W width.
- rf_addr_o truncates to 5 bits.
- Only idx[3:0] is shown in the display tag.

Decomposition:
- Shared package dbg_pkg: state encoding constants S_INSTR..S_LED (3-bit), ALU_ITEMS = 5, fill constant 32'hFFFF_FFFF.
- One sub-module: dbg_wrap_cnt (params N, IDX_W; inputs clr, en; output idx), instantiated four times (reg, alu, dmem, led).
- State decode and output mux stay in dbg_disp_scan.

Test Plan:
- Reset with sel_i=4'b0100, rf_data_i = 32'hABCD_1234 -> display 0 for one edge (transition), then 64'h0000_0000_0BCD_1234, then 64'h0000_0000_1BCD_1234; rf_addr_o steps 0,1,2.
- S_REG, RF_NUM=32: walk through index 31 -> shows tag 4'hF; next edge rf_addr_o wraps to 0 and tag 0. Assert hold_i at idx 5 for 3 edges -> rf_addr_o stays 5 while display keeps updating.
- sel_i=4'b0010 with A=1, B=2, C=3, zero=1 -> after transition edge: 1, 2, 3, 1, FFFF_FFFF, then 1 again (wrap after 5 items).
- In S_DMEM at idx 7, switch to S_ALU then back to S_DMEM -> dm_addr_o restarts at 0; display is 0 on each transition edge.
- led_i=1 while sel_i=4'b1000 -> S_LED; disp_mode_o=1; led_idx_o walks 0..47 then wraps to 0; display equals led_pat_i. Drop led_i -> S_INSTR and disp_mode_o=0 on that edge.
- Assert rstn low asynchronously mid-LED walk at idx 20 -> outputs go to 0 and led_idx_o to 0 before the next clock edge.
